// File: rtl/multi_debounce_pkg.sv
//==== multi_debounce_pkg : shared constants, helpers and channel output type ====
//==== rev 1.0 ====
`default_nettype none

package multi_debounce_pkg;

   localparam int c_CLK_HZ                 = 50_000_000;
   localparam int c_DEFAULT_DEBOUNCE_LIMIT = 5_000_000;
   localparam int c_DEFAULT_REPEAT_DELAY   = 25_000_000;
   localparam int c_DEFAULT_REPEAT_RATE    = 5_000_000;

   typedef struct packed {
      logic debounced;
      logic rise;
      logic fall;
      logic rpt;
   } chan_out_t;

   function automatic int ms_to_cycles(input int ms);
      return (c_CLK_HZ / 1000) * ms;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_debounce_channel.sv
//==== multi_debounce_channel : sync, bounce filter, edge and repeat for one input ====
//==== rev 1.0 ====
`default_nettype none

module multi_debounce_channel
   import multi_debounce_pkg::*;
#(
   parameter int   DEBOUNCE_LIMIT = c_DEFAULT_DEBOUNCE_LIMIT,
   parameter int   SYNC_STAGES    = 2,
   parameter int   REPEAT_EN      = 0,
   parameter int   REPEAT_DELAY   = c_DEFAULT_REPEAT_DELAY,
   parameter int   REPEAT_RATE    = c_DEFAULT_REPEAT_RATE,
   parameter logic RESET_LEVEL    = 1'b0
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_bouncy,
   output chan_out_t o_ch
);

   localparam int            CW        = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] c_CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_state;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync_out;
   logic                   w_differs;
   logic                   w_accept;
   logic                   w_repeat;

   assign w_sync_out = r_sync[SYNC_STAGES-1];
   assign w_differs  = (w_sync_out != r_state);
   assign w_accept   = w_differs && (r_cnt == c_CNT_MAX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= {SYNC_STAGES{RESET_LEVEL}};
         r_state <= RESET_LEVEL;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_bouncy};
         r_rise <= w_accept && w_sync_out;
         r_fall <= w_accept && !w_sync_out;
         // Any cycle where the synchronised input agrees with the state restarts qualification.
         if (w_accept) begin
            r_state <= w_sync_out;
            r_cnt   <= '0;
         end else if (w_differs) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end

   if (REPEAT_EN != 0) begin : g_repeat
      localparam int            RW      = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
      localparam logic [RW-1:0] c_FIRST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] c_NEXT  = RW'(REPEAT_RATE - 1);

      logic [RW-1:0] r_rpt;
      logic          r_past_first;
      logic          r_repeat;
      logic [RW-1:0] w_target;

      assign w_target = r_past_first ? c_NEXT : c_FIRST;

      // Held low, or accepting an edge (rise arms, fall cancels): counter restarts from zero.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_rpt        <= '0;
            r_past_first <= 1'b0;
            r_repeat     <= 1'b0;
         end else if (!r_state || w_accept) begin
            r_rpt        <= '0;
            r_past_first <= 1'b0;
            r_repeat     <= 1'b0;
         end else if (r_rpt == w_target) begin
            r_rpt        <= '0;
            r_past_first <= 1'b1;
            r_repeat     <= 1'b1;
         end else begin
            r_rpt    <= r_rpt + 1'b1;
            r_repeat <= 1'b0;
         end
      end

      assign w_repeat = r_repeat;
   end else begin : g_no_repeat
      assign w_repeat = 1'b0;
   end

   assign o_ch = '{debounced: r_state, rise: r_rise, fall: r_fall, rpt: w_repeat};

endmodule

`default_nettype wire

// File: rtl/multi_debounce.sv
//==== multi_debounce : N-channel debouncer with edge and auto-repeat pulses ====
//==== rev 1.0 ====
`default_nettype none

module multi_debounce
   import multi_debounce_pkg::*;
#(
   parameter int   NUM_CHANNELS   = 4,
   parameter int   DEBOUNCE_LIMIT = c_DEFAULT_DEBOUNCE_LIMIT,
   parameter int   SYNC_STAGES    = 2,
   parameter int   REPEAT_EN      = 0,
   parameter int   REPEAT_DELAY   = c_DEFAULT_REPEAT_DELAY,
   parameter int   REPEAT_RATE    = c_DEFAULT_REPEAT_RATE,
   parameter logic RESET_LEVEL    = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_CHANNELS-1:0] i_bouncy,
   output logic [NUM_CHANNELS-1:0] o_debounced,
   output logic [NUM_CHANNELS-1:0] o_rise,
   output logic [NUM_CHANNELS-1:0] o_fall,
   output logic [NUM_CHANNELS-1:0] o_repeat
);

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
      chan_out_t w_ch;

      multi_debounce_channel #(
         .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
         .SYNC_STAGES    (SYNC_STAGES),
         .REPEAT_EN      (REPEAT_EN),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE),
         .RESET_LEVEL    (RESET_LEVEL)
      ) u_channel (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_bouncy (i_bouncy[k]),
         .o_ch     (w_ch)
      );

      assign o_debounced[k] = w_ch.debounced;
      assign o_rise[k]      = w_ch.rise;
      assign o_fall[k]      = w_ch.fall;
      assign o_repeat[k]    = w_ch.rpt;
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_debounce.sv
//==== tb_multi_debounce : scoreboard bench with a window-based reference model ====
//==== rev 1.0 ====
`default_nettype none

module tb_multi_debounce;

   localparam int N     = 4;
   localparam int LIMIT = 4;
   localparam int SYNC  = 2;
   localparam int RD    = 10;
   localparam int RR    = 3;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic [N-1:0] bouncy = '0;
   logic [N-1:0] deb, rise, fall, rep;
   logic [N-1:0] deb0, rise0, fall0, rep0;

   always #5 clk = ~clk;

   multi_debounce #(
      .NUM_CHANNELS (N), .DEBOUNCE_LIMIT (LIMIT), .SYNC_STAGES (SYNC),
      .REPEAT_EN (1), .REPEAT_DELAY (RD), .REPEAT_RATE (RR), .RESET_LEVEL (1'b0)
   ) dut (
      .i_clk (clk), .i_rst_n (rst_n), .i_bouncy (bouncy),
      .o_debounced (deb), .o_rise (rise), .o_fall (fall), .o_repeat (rep)
   );

   multi_debounce #(
      .NUM_CHANNELS (N), .DEBOUNCE_LIMIT (LIMIT), .SYNC_STAGES (SYNC),
      .REPEAT_EN (0), .REPEAT_DELAY (RD), .REPEAT_RATE (RR), .RESET_LEVEL (1'b0)
   ) dut_norep (
      .i_clk (clk), .i_rst_n (rst_n), .i_bouncy (bouncy),
      .o_debounced (deb0), .o_rise (rise0), .o_fall (fall0), .o_repeat (rep0)
   );

   typedef struct {
      logic [N-1:0] deb;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] rep;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   int           pushed = 0;
   int           popped = 0;

   // Reference state: raw inputs per edge since reset release, accepted level, edge of last rise.
   logic [N-1:0] hist[$];
   logic [N-1:0] m_level = '0;
   int           rise_edge[N];

   function automatic logic s_at(input int n, input int ch);
      logic [N-1:0] v;
      if (n < SYNC) return 1'b0;
      v = hist[n-SYNC];
      return v[ch];
   endfunction

   // A new level is accepted once the synchronised input has disagreed with it for LIMIT edges.
   task automatic model_edge(input logic [N-1:0] v);
      exp_t e;
      int   n;
      logic acc;
      hist.push_back(v);
      n      = hist.size() - 1;
      e.rise = '0;
      e.fall = '0;
      e.rep  = '0;
      for (int ch = 0; ch < N; ch++) begin
         acc = (n >= LIMIT - 1);
         for (int m = n - LIMIT + 1; acc && m <= n; m++)
            if (s_at(m, ch) == m_level[ch]) acc = 1'b0;
         e.rep[ch] = m_level[ch] && !acc && (n - rise_edge[ch] >= RD)
                     && (((n - rise_edge[ch] - RD) % RR) == 0);
         if (acc) begin
            m_level[ch] = ~m_level[ch];
            if (m_level[ch]) begin
               e.rise[ch]    = 1'b1;
               rise_edge[ch] = n;
            end else begin
               e.fall[ch] = 1'b1;
            end
         end
      end
      e.deb = m_level;
      sb.push_back(e);
      pushed++;
   endtask

   task automatic step(input logic [N-1:0] v);
      bouncy = v;
      model_edge(v);
      @(negedge clk);
   endtask

   task automatic do_reset(input int cyc, input logic [N-1:0] v);
      exp_t z;
      rst_n  = 1'b0;
      bouncy = v;
      #1;
      checks++;
      if ({deb, rise, fall, rep, deb0, rise0, fall0, rep0} !== '0) begin
         errors++;
         $display("FAIL async_reset t=%0t got deb=%h rise=%h fall=%h rep=%h norep_deb=%h norep_rep=%h expected all 0",
                  $time, deb, rise, fall, rep, deb0, rep0);
      end
      hist.delete();
      m_level = '0;
      z.deb = '0; z.rise = '0; z.fall = '0; z.rep = '0;
      for (int i = 0; i < cyc; i++) begin
         sb.push_back(z);
         pushed++;
         @(negedge clk);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            popped++;
            checks++;
            if ({deb, rise, fall, rep} !== {mon_e.deb, mon_e.rise, mon_e.fall, mon_e.rep}) begin
               errors++;
               $display("FAIL dut t=%0t got deb=%h rise=%h fall=%h rep=%h expected deb=%h rise=%h fall=%h rep=%h",
                        $time, deb, rise, fall, rep, mon_e.deb, mon_e.rise, mon_e.fall, mon_e.rep);
            end
            checks++;
            if ({deb0, rise0, fall0, rep0} !== {mon_e.deb, mon_e.rise, mon_e.fall, 4'h0}) begin
               errors++;
               $display("FAIL dut_norep t=%0t got deb=%h rise=%h fall=%h rep=%h expected deb=%h rise=%h fall=%h rep=0",
                        $time, deb0, rise0, fall0, rep0, mon_e.deb, mon_e.rise, mon_e.fall);
            end
         end
      end
   end

   initial begin
      logic [N-1:0] v;
      int           p;
      int           len;
      for (int ch = 0; ch < N; ch++) rise_edge[ch] = 0;

      @(negedge clk);
      do_reset(3, 4'hF);
      repeat (10) step(4'hF);

      do_reset(2, 4'h0);
      repeat (8) step(4'h0);
      repeat (10) step(4'h1);

      // ch1 bounce: short high runs separated by single low cycles, then a held press
      repeat (3) step(4'h3);
      step(4'h1);
      repeat (3) step(4'h3);
      step(4'h1);
      repeat (8) step(4'h3);

      // ch2 held long enough for several auto-repeats, then released
      repeat (25) step(4'h7);
      repeat (8) step(4'h3);

      // ch0 rises while ch3 falls on the same edge
      repeat (8) step(4'h8);
      repeat (8) step(4'h1);

      // reset while ch1 is mid-qualification, then while ch2 is repeating
      repeat (3) step(4'h3);
      do_reset(2, 4'h3);
      repeat (18) step(4'h4);
      do_reset(2, 4'h4);
      repeat (8) step(4'h0);

      v = '0;
      for (int seg = 0; seg < 60; seg++) begin
         p   = ($urandom_range(0, 1) != 0) ? 3 : 30;
         len = $urandom_range(20, 80);
         for (int i = 0; i < len; i++) begin
            for (int ch = 0; ch < N; ch++)
               if ($urandom_range(0, 99) < p) v[ch] = ~v[ch];
            step(v);
         end
         if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3), v);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (popped != pushed || sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain popped=%0d pushed=%0d left=%0d expected popped==pushed left=0",
                  popped, pushed, sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
